key_switch_io: RTL
==================

Name: key_switch_io

Overview:
- Memory-mapped input responder on the processor data bus. Serves the KEY and SW windows to the core's load/store path.
- Synchronizes and debounces the raw board KEY[3:0] and SW[9:0] pins.
- Presents clean levels, plus sticky write-1-to-clear event registers so software can poll without missing presses.
- Sits beside data memory; its rd_data is muxed into the load-result path when sel is high.

Parameters:
- DBITS, 32, bus data/address width.
- KEY_BITS, 4, number of push-buttons.
- SW_BITS, 10, number of slide switches.
- DEB_CYCLES, 500000, consecutive stable synchronized cycles required to accept a new level (must be >= 2).
- KEY_ACTIVE_LOW, 1, when 1 the raw KEY pin is inverted so pressed reads as 1.
- ADDR_KEY, 32'hF0000010, debounced key level register (RO).
- ADDR_SW, 32'hF0000014, debounced switch level register (RO).
- ADDR_KEDGE, 32'hF0000018, key press/overrun sticky register (W1C).
- ADDR_SEDGE, 32'hF000001C, switch change sticky register (W1C).

Ports:
- clk, input, 1, system clock (PLL c0).
- reset, input, 1, asynchronous active-low reset.
- addr, input, DBITS, bus address (ALU result).
- wr_en, input, 1, store strobe; sampled on the rising edge of clk.
- wr_data, input, DBITS, store data.
- key_in, input, KEY_BITS, raw KEY pins.
- sw_in, input, SW_BITS, raw SW pins.
- rd_data, output, DBITS, combinational read data.
- sel, output, 1, high when addr equals any of the four register addresses.
- key_irq, output, 1, OR of KEDGE[KEY_BITS-1:0] (status only).

Behaviour:
- Reset (reset low, async): all sync flops, counters, debounced levels, KEDGE and SEDGE clear to 0.
  - rd_data and sel remain combinational functions of addr.
  - Reset mid-count discards the partial count.
- Input conditioning, per bit:
  - Two-flop synchronizer produces s.
  - If s == deb: cnt <= 0.
  - Else if cnt == DEB_CYCLES-1: deb <= s, cnt <= 0.
  - Else: cnt <= cnt+1.
  - A glitch shorter than DEB_CYCLES synchronized cycles never reaches deb.
  - Latency: a clean pin change appears in deb on the (DEB_CYCLES+2)th rising edge after it.
  - Counter width is clog2(DEB_CYCLES).
- Key polarity: the raw key is inverted when KEY_ACTIVE_LOW=1, so pressed = 1; keys reset to "not pressed".
- Switches reset to 0. After reset, the first debounce of any switch at 1 sets its SEDGE bit; software clears it at boot.
- KEDGE layout:
  - bits[KEY_BITS-1:0] press: set on the edge where deb goes 0->1.
  - bits[2*KEY_BITS-1:KEY_BITS] overrun: set when a press occurs while the press bit is already 1.
  - Release does not set any bit.
- SEDGE layout: bits[SW_BITS-1:0] set on any deb change of that switch.
- W1C semantics:
  - A write to ADDR_KEDGE or ADDR_SEDGE clears each bit whose wr_data bit is 1; a 0 bit leaves that bit unchanged.
  - If a set event and a clear occur on the same edge, set wins; the event is never lost.
  - Writes to ADDR_KEY, ADDR_SW or unmapped addresses are ignored.
- Reads:
  - rd_data is valid in the same cycle as addr, with no side effects.
  - Unused upper bits read 0.
  - An unmapped addr gives rd_data = 0 and sel = 0.
- Address decode is full 32-bit equality; no aliasing.

Decomposition:
- Shared package `io_map_pkg` holds:
  - the ADDR_* constants, shared with the core top and data memory decode;
  - KEY_BITS and SW_BITS;
  - the KEDGE field offsets.
- One sub-module, `debounce_bit`:
  - two-flop synchronizer plus stability counter;
  - parameter DEB_CYCLES;
  - ports clk, reset, raw, deb, rise, fall.
- It is instantiated KEY_BITS+SW_BITS times via generate.

Test Plan (DEB_CYCLES=4, KEY_ACTIVE_LOW=1):
- Reset, then read all four addresses: KEY=0, SW=0, KEDGE=0, SEDGE=0. Read 0xF0000020: rd_data=0, sel=0.
- Drive key_in=4'b1110 from edge 0 and hold: KEY reads 0 through edge 5 and 32'h1 from edge 6. KEDGE=32'h1 and key_irq=1 from edge 6.
- Pulse sw_in[3]=1 for 3 cycles, then 0: SW stays 0 and SEDGE stays 0. Hold it for 10 cycles instead: SW=32'h8, SEDGE=32'h8.
- With KEDGE=32'h1, release and re-press KEY0: KEDGE=32'h11 (overrun). Write 32'h10 to 0xF0000018: KEDGE=32'h1. Write 32'h1: KEDGE=0, key_irq=0.
- Write 32'h1 to ADDR_KEDGE on the same edge a new KEY0 press debounces: KEDGE=32'h1 afterwards (set wins).
- Assert reset at cycle 3 of a 4-cycle debounce and release: KEY stays 0. The full DEB_CYCLES+2 latency restarts from reset release.

Source files
------------

// File: rtl/io_map_pkg.sv
// Shared I/O map for the board key/switch responder.
// Register addresses, widths and KEDGE field offsets used by core and memory decode.
package io_map_pkg;

    localparam int unsigned KEY_BITS = 4;
    localparam int unsigned SW_BITS  = 10;

    localparam logic [31:0] ADDR_KEY   = 32'hF000_0010;
    localparam logic [31:0] ADDR_SW    = 32'hF000_0014;
    localparam logic [31:0] ADDR_KEDGE = 32'hF000_0018;
    localparam logic [31:0] ADDR_SEDGE = 32'hF000_001C;

    localparam int unsigned KEDGE_PRESS_LSB = 0;
    localparam int unsigned KEDGE_OVR_LSB   = KEY_BITS;

endpackage

// File: rtl/debounce_bit.sv
// Two-flop synchronizer plus stability counter for one raw board pin.
// rise/fall are high in the cycle before the edge that updates deb.
module debounce_bit #(
    parameter int unsigned DEB_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic deb,
    output logic rise,
    output logic fall
);

    localparam int unsigned CW = $clog2(DEB_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

    logic          meta_q;
    logic          s_q;
    logic          deb_q;
    logic          deb_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        deb_d = deb_q;
        cnt_d = cnt_q;
        if (s_q == deb_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            deb_d = s_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_q <= 1'b0;
            s_q    <= 1'b0;
            deb_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            meta_q <= raw;
            s_q    <= meta_q;
            deb_q  <= deb_d;
            cnt_q  <= cnt_d;
        end
    end

    assign deb  = deb_q;
    assign rise = deb_d & ~deb_q;
    assign fall = ~deb_d & deb_q;

endmodule

// File: rtl/key_switch_io.sv
// Memory-mapped KEY/SW responder: debounced levels plus sticky W1C event registers.
// Reads are combinational on addr; stores to the edge registers clear bits, set wins.
module key_switch_io #(
    parameter int unsigned DBITS          = 32,
    parameter int unsigned KEY_BITS       = io_map_pkg::KEY_BITS,
    parameter int unsigned SW_BITS        = io_map_pkg::SW_BITS,
    parameter int unsigned DEB_CYCLES     = 500000,
    parameter bit          KEY_ACTIVE_LOW = 1'b1,
    parameter logic [DBITS-1:0] ADDR_KEY   = DBITS'(io_map_pkg::ADDR_KEY),
    parameter logic [DBITS-1:0] ADDR_SW    = DBITS'(io_map_pkg::ADDR_SW),
    parameter logic [DBITS-1:0] ADDR_KEDGE = DBITS'(io_map_pkg::ADDR_KEDGE),
    parameter logic [DBITS-1:0] ADDR_SEDGE = DBITS'(io_map_pkg::ADDR_SEDGE)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [DBITS-1:0]    addr,
    input  logic                wr_en,
    input  logic [DBITS-1:0]    wr_data,
    input  logic [KEY_BITS-1:0] key_in,
    input  logic [SW_BITS-1:0]  sw_in,
    output logic [DBITS-1:0]    rd_data,
    output logic                sel,
    output logic                key_irq
);

    import io_map_pkg::*;

    logic [KEY_BITS-1:0] key_raw;
    logic [KEY_BITS-1:0] key_deb;
    logic [KEY_BITS-1:0] key_rise;
    logic [KEY_BITS-1:0] key_fall;
    logic [SW_BITS-1:0]  sw_deb;
    logic [SW_BITS-1:0]  sw_rise;
    logic [SW_BITS-1:0]  sw_fall;

    logic [KEY_BITS-1:0] press_q, press_d;
    logic [KEY_BITS-1:0] ovr_q, ovr_d;
    logic [SW_BITS-1:0]  sedge_q, sedge_d;
    logic                kedge_wr;
    logic                sedge_wr;
    logic                unused_ok;

    assign key_raw = KEY_ACTIVE_LOW ? ~key_in : key_in;

    for (genvar i = 0; i < KEY_BITS; i++) begin : g_key
        debounce_bit #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
            .clk   (clk),
            .reset (reset),
            .raw   (key_raw[i]),
            .deb   (key_deb[i]),
            .rise  (key_rise[i]),
            .fall  (key_fall[i])
        );
    end

    for (genvar i = 0; i < SW_BITS; i++) begin : g_sw
        debounce_bit #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
            .clk   (clk),
            .reset (reset),
            .raw   (sw_in[i]),
            .deb   (sw_deb[i]),
            .rise  (sw_rise[i]),
            .fall  (sw_fall[i])
        );
    end

    assign kedge_wr = wr_en && (addr == ADDR_KEDGE);
    assign sedge_wr = wr_en && (addr == ADDR_SEDGE);

    // Overrun looks at the press bit before this edge's clear is applied.
    always_comb begin
        press_d = press_q;
        ovr_d   = ovr_q;
        sedge_d = sedge_q;
        if (kedge_wr) begin
            press_d = press_q & ~wr_data[KEDGE_PRESS_LSB +: KEY_BITS];
            ovr_d   = ovr_q & ~wr_data[KEDGE_OVR_LSB +: KEY_BITS];
        end
        if (sedge_wr) begin
            sedge_d = sedge_q & ~wr_data[SW_BITS-1:0];
        end
        ovr_d   = ovr_d | (key_rise & press_q);
        press_d = press_d | key_rise;
        sedge_d = sedge_d | sw_rise | sw_fall;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            press_q <= '0;
            ovr_q   <= '0;
            sedge_q <= '0;
        end else begin
            press_q <= press_d;
            ovr_q   <= ovr_d;
            sedge_q <= sedge_d;
        end
    end

    always_comb begin
        rd_data = '0;
        sel     = 1'b0;
        if (addr == ADDR_KEY) begin
            sel                    = 1'b1;
            rd_data[KEY_BITS-1:0]  = key_deb;
        end else if (addr == ADDR_SW) begin
            sel                    = 1'b1;
            rd_data[SW_BITS-1:0]   = sw_deb;
        end else if (addr == ADDR_KEDGE) begin
            sel                                  = 1'b1;
            rd_data[KEDGE_PRESS_LSB +: KEY_BITS] = press_q;
            rd_data[KEDGE_OVR_LSB +: KEY_BITS]   = ovr_q;
        end else if (addr == ADDR_SEDGE) begin
            sel                    = 1'b1;
            rd_data[SW_BITS-1:0]   = sedge_q;
        end
    end

    assign key_irq   = |press_q;
    assign unused_ok = ^{key_fall, wr_data};

endmodule
